spike_event_fifo: RTL and testbench

Output-side buffer that sits directly downstream of `neuron_core`. It captures spike events (firing neuron index) as the core produces them and holds them in a circular FIFO. The management SoC drains them over the same Wishbone slave bus through a small register window. The block also provides overflow accounting and a level/overflow interrupt toward `user_irq`.

---
 rtl/spike_event_fifo.sv | 137 +++++++++++++
 tb/tb_spike_event_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// Spike event FIFO downstream of neuron_core, drained over a Wishbone register window.
// Tracks dropped events when full and raises a level/overflow interrupt.
module spike_event_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ID_W      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spike_valid_i,
    input  logic [ID_W-1:0] spike_id_i,
    output logic            spike_ready_o,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic            irq_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             irq_en_q, irq_en_d;
    logic [7:0]       thresh_q, thresh_d;
    logic             ack_q;
    logic [31:0]      dat_q, rdata;
    logic             irq_q, irq_d;

    logic       sel, acc, pop, ctrl_wr, thr_wr, flush, clr, push, drop, full, empty;
    logic [1:0] off;
    logic [7:0] cnt_disp;
    logic       unused;

    assign unused = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:8]};

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign off   = wbs_adr_i[3:2];
    assign sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // A request is taken only while ack is low, so each access is acked exactly once.
    assign acc     = sel & ~ack_q;
    assign pop     = acc & ~wbs_we_i & (off == 2'd0) & ~empty;
    assign ctrl_wr = acc & wbs_we_i & (off == 2'd2);
    assign thr_wr  = acc & wbs_we_i & (off == 2'd3);
    assign flush   = ctrl_wr & wbs_dat_i[0];
    assign clr     = ctrl_wr & wbs_dat_i[1];
    // Pop frees a slot before the push is evaluated; a flush swallows any push.
    assign push = spike_valid_i & (~full | pop) & ~flush;
    assign drop = spike_valid_i & full & ~pop & ~flush;

    assign cnt_disp = (32'(count_q) > 32'd255) ? 8'hFF : 8'(count_q);

    always_comb begin
        rdata = 32'h0;
        unique case (off)
            2'd0: if (!empty) rdata = {1'b1, {(31 - ID_W){1'b0}}, mem[rd_ptr_q]};
            2'd1: rdata = {drop_cnt_q, 5'b0, ovf_q, full, empty, cnt_disp};
            2'd2: rdata = {29'b0, irq_en_q, 2'b0};
            2'd3: rdata = {24'b0, thresh_q};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        irq_en_d   = irq_en_q;
        thresh_d   = thresh_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        if (clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (ctrl_wr) irq_en_d = wbs_dat_i[2];
        if (thr_wr)  thresh_d = wbs_dat_i[7:0];
    end

    assign irq_d = irq_en_q & (((32'(count_q) >= 32'(thresh_q)) && (thresh_q != 8'd0)) | ovf_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            irq_en_q   <= 1'b0;
            thresh_q   <= 8'd1;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            irq_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            ack_q      <= acc;
            dat_q      <= (acc && !wbs_we_i) ? rdata : 32'h0;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= spike_id_i;
    end

    assign spike_ready_o = ~full;
    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed self-checking bench for spike_event_fifo (DEPTH=16, ID_W=8).
module tb_spike_event_fifo;
    localparam logic [31:0] BASE = 32'h3000_1000;
    localparam logic [3:0] OffData = 4'h0, OffStatus = 4'h4, OffCtrl = 4'h8, OffThresh = 4'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        spike_valid;
    logic [7:0]  spike_id;
    logic        spike_ready;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat, rdat;
    logic        ack, irq;
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    spike_event_fifo #(.DEPTH(16), .ID_W(8), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .spike_valid_i (spike_valid),
        .spike_id_i    (spike_id),
        .spike_ready_o (spike_ready),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (4'hF),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .irq_o         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic push_one(input logic [7:0] id);
        spike_valid = 1'b1;
        spike_id    = id;
        @(posedge clk); #1;
        spike_valid = 1'b0;
    endtask

    task automatic wb_access(input logic w, input logic [3:0] off, input logic [31:0] wd,
                             input logic sv, input logic [7:0] sid, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = 32'h0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {28'h0, off}; wdat = wd;
        spike_valid = sv; spike_id = sid;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            spike_valid = 1'b0;
            if (ack) begin
                got   = 1'b1;
                rdata = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) check("ack_timeout", 32'(ack), 32'd1);
    endtask

    task automatic rd_reg(input logic [3:0] off, output logic [31:0] rdata);
        wb_access(1'b0, off, 32'h0, 1'b0, 8'h0, rdata);
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_access(1'b1, off, wd, 1'b0, 8'h0, dummy);
    endtask

    initial begin
        logic ack_seen;
        rst = 1'b1; spike_valid = 1'b0; spike_id = 8'h0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ready", 32'(spike_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rd_reg(OffStatus, rd);
        check("status_reset", rd, 32'h0000_0100);
        rd_reg(OffThresh, rd);
        check("thresh_reset", rd, 32'h0000_0001);

        // Three pushes then four reads, the last on an empty FIFO.
        push_one(8'd3); push_one(8'd7); push_one(8'd9);
        rd_reg(OffData, rd); check("data0", rd, 32'h8000_0003);
        rd_reg(OffData, rd); check("data1", rd, 32'h8000_0007);
        @(posedge clk); #1;
        check("dat_zero_no_ack", rdat, 32'h0);
        rd_reg(OffData, rd); check("data2", rd, 32'h8000_0009);
        rd_reg(OffData, rd); check("data_empty", rd, 32'h0);
        rd_reg(OffStatus, rd); check("status_drained", rd, 32'h0000_0100);

        // Out-of-window address is never acked.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10;
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check("decode_miss", 32'(ack_seen), 32'd0);
        @(posedge clk); #1;

        // Overfill: 20 events into 16 slots.
        for (int i = 0; i < 20; i++) push_one(8'(i));
        check("ready_full", 32'(spike_ready), 32'd0);
        check("irq_disabled", 32'(irq), 32'd0);
        rd_reg(OffStatus, rd); check("status_overflow", rd, 32'h0004_0610);
        for (int i = 0; i < 16; i++) begin
            rd_reg(OffData, rd);
            check($sformatf("ovf_data%0d", i), rd, 32'h8000_0000 | i);
        end
        rd_reg(OffStatus, rd); check("status_ovf_empty", rd, 32'h0004_0500);
        wr_reg(OffCtrl, 32'h2);
        rd_reg(OffStatus, rd); check("status_clear_ovf", rd, 32'h0000_0100);

        // Full FIFO: push coinciding with the pop edge is accepted without a drop.
        for (int i = 0; i < 16; i++) push_one(8'(8'h20 + i));
        wb_access(1'b0, OffData, 32'h0, 1'b1, 8'hAA, rd);
        check("full_pop", rd, 32'h8000_0020);
        rd_reg(OffStatus, rd); check("status_full_swap", rd, 32'h0000_0210);
        for (int i = 1; i < 16; i++) begin
            rd_reg(OffData, rd);
            check($sformatf("swap_data%0d", i), rd, 32'h8000_0020 + i);
        end
        rd_reg(OffData, rd); check("swap_last", rd, 32'h8000_00AA);

        // Level interrupt at threshold 4.
        wr_reg(OffThresh, 32'h4);
        wr_reg(OffCtrl, 32'h4);
        rd_reg(OffCtrl, rd); check("ctrl_readback", rd, 32'h0000_0004);
        for (int i = 0; i < 4; i++) push_one(8'(8'h40 + i));
        check("irq_lag", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_level", 32'(irq), 32'd1);
        rd_reg(OffData, rd); check("irq_pop_data", rd, 32'h8000_0040);
        check("irq_hold", 32'(irq), 32'd1);
        @(posedge clk); #1;
        check("irq_drop", 32'(irq), 32'd0);

        // Five entries queued, flush coinciding with a push.
        push_one(8'h50); push_one(8'h51);
        wb_access(1'b1, OffCtrl, 32'h1, 1'b1, 8'h77, rd);
        rd_reg(OffStatus, rd); check("status_flush", rd, 32'h0000_0100);
        push_one(8'h55);
        rd_reg(OffData, rd); check("post_flush_data", rd, 32'h8000_0055);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
